// File: rtl/counter_pkg.sv
// counter_pkg: shared bounds, action encoding and Gray helper for the counter library
package counter_pkg;
  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;
  typedef enum logic [2:0] {ACT_HOLD, ACT_CLR, ACT_LOAD, ACT_INC, ACT_DEC} act_e;
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] value);
    return value ^ (value >> 1);
  endfunction
endpackage

// File: rtl/counter_next_state.sv
// counter_next_state: combinational next count, wrap and load clamp for d_counter_updown
module counter_next_state
  import counter_pkg::*;
#(
  parameter int     WIDTH       = 8,
  parameter longint MODULUS     = 256,
  parameter longint RESET_VALUE = 0
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_en,
  input  logic             i_up_dn,
  input  logic             i_sclr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_next_count,
  output logic             o_next_wrap,
  output logic             o_next_load_err
);
  // load_value < MODULUS is the same as load_value <= MODULUS-1, which stays in WIDTH bits
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
  act_e w_act;
  logic w_at_max, w_at_zero, w_load_ok;
  always_comb begin
    w_act           = i_sclr ? ACT_CLR : i_load ? ACT_LOAD : !i_en ? ACT_HOLD : i_up_dn ? ACT_INC : ACT_DEC;
    w_at_max        = i_count == MAX_VAL;
    w_at_zero       = i_count == '0;
    w_load_ok       = i_load_value <= MAX_VAL;
    o_next_count    = w_act == ACT_CLR  ? RST_VAL :
                      w_act == ACT_LOAD ? (w_load_ok ? i_load_value : MAX_VAL) :
                      w_act == ACT_INC  ? (w_at_max ? '0 : i_count + WIDTH'(1)) :
                      w_act == ACT_DEC  ? (w_at_zero ? MAX_VAL : i_count - WIDTH'(1)) :
                      i_count;
    o_next_wrap     = (w_act == ACT_INC && w_at_max) || (w_act == ACT_DEC && w_at_zero);
    o_next_load_err = w_act == ACT_LOAD && !w_load_ok;
  end
endmodule

// File: rtl/d_counter_updown.sv
// d_counter_updown: parametrised up/down modulo counter with clear, load, wrap pulse and Gray output
module d_counter_updown
  import counter_pkg::*;
#(
  parameter int     WIDTH       = 8,
  parameter longint MODULUS     = 256,
  parameter longint RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             load_err
);
  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("d_counter_updown: WIDTH out of range");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("d_counter_updown: MODULUS out of range");
  end
  if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset
    $error("d_counter_updown: RESET_VALUE must be below MODULUS");
  end
  localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);
  logic [WIDTH-1:0] r_count, r_gray, w_next_count, w_next_gray;
  logic r_wrap, r_load_err, w_next_wrap, w_next_load_err;
  counter_next_state #(.WIDTH(WIDTH), .MODULUS(MODULUS), .RESET_VALUE(RESET_VALUE)) u_next (
    .i_count        (r_count),
    .i_en           (en),
    .i_up_dn        (up_dn),
    .i_sclr         (sclr),
    .i_load         (load),
    .i_load_value   (load_value),
    .o_next_count   (w_next_count),
    .o_next_wrap    (w_next_wrap),
    .o_next_load_err(w_next_load_err)
  );
  // Gray is taken from the next state so it lines up with count without extra lag
  assign w_next_gray = WIDTH'(bin2gray(MAX_WIDTH'(w_next_count)));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= RST_VAL;
      r_gray     <= RST_GRAY;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_count    <= w_next_count;
      r_gray     <= w_next_gray;
      r_wrap     <= w_next_wrap;
      r_load_err <= w_next_load_err;
    end
  end
  assign count    = r_count;
  assign gray     = r_gray;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;
endmodule
